// File: rtl/uart_cmd_decoder.sv
// Receive-side command decoder: unloads bytes from the UART receiver and parses
// A5/CMD/ARG/CHK frames into scan-control registers.
module uart_cmd_decoder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  RATE_DEFAULT   = 8'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       uld_rx_data,
  output logic       rx_enable,
  output logic       scan_enable,
  output logic [7:0] rate_div,
  output logic       ping_pulse,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, CMD, ARG, CHK} state_t;

  state_t      state, state_next;
  logic        pending, byte_valid;
  logic [7:0]  byte_reg;
  logic [7:0]  cmd_reg, cmd_next;
  logic [7:0]  arg_reg, arg_next;
  logic [15:0] tmo, tmo_next;
  logic        scan_next, ping_next, valid_next, err_inc;
  logic [7:0]  rate_next, code_next, err_next;

  always_ff @(posedge clock) begin
    if (reset) rx_enable <= 1'b0;
    else       rx_enable <= 1'b1;
  end

  // pending stays set until the receiver shows empty, so one byte is never unloaded twice
  always_ff @(posedge clock) begin
    if (reset) begin
      uld_rx_data <= 1'b0;
      byte_valid  <= 1'b0;
      pending     <= 1'b0;
      byte_reg    <= 8'h00;
    end else begin
      uld_rx_data <= 1'b0;
      byte_valid  <= 1'b0;
      if (!rx_empty && !pending) begin
        uld_rx_data <= 1'b1;
        byte_valid  <= 1'b1;
        byte_reg    <= rx_data;
        pending     <= 1'b1;
      end else if (rx_empty) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      cmd_reg     <= 8'h00;
      arg_reg     <= 8'h00;
      tmo         <= 16'd0;
      scan_enable <= 1'b0;
      rate_div    <= RATE_DEFAULT;
      ping_pulse  <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      err_count   <= 8'h00;
    end else begin
      state       <= state_next;
      cmd_reg     <= cmd_next;
      arg_reg     <= arg_next;
      tmo         <= tmo_next;
      scan_enable <= scan_next;
      rate_div    <= rate_next;
      ping_pulse  <= ping_next;
      cmd_valid   <= valid_next;
      cmd_code    <= code_next;
      err_count   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_next   = cmd_reg;
    arg_next   = arg_reg;
    tmo_next   = tmo;
    scan_next  = scan_enable;
    rate_next  = rate_div;
    code_next  = cmd_code;
    ping_next  = 1'b0;
    valid_next = 1'b0;
    err_inc    = 1'b0;
    err_next   = err_count;

    case (state)
      HUNT: begin
        tmo_next = 16'd0;
        if (byte_valid && byte_reg == 8'hA5) state_next = CMD;
      end
      default: begin
        // an arriving byte takes priority over an expiring timeout
        if (byte_valid) begin
          tmo_next = 16'd0;
          case (state)
            CMD: begin
              cmd_next   = byte_reg;
              state_next = ARG;
            end
            ARG: begin
              arg_next   = byte_reg;
              state_next = CHK;
            end
            CHK: begin
              state_next = HUNT;
              if (byte_reg == (8'hA5 ^ cmd_reg ^ arg_reg)) begin
                case (cmd_reg)
                  8'h01, 8'h02, 8'h03, 8'h04: begin
                    valid_next = 1'b1;
                    code_next  = cmd_reg;
                    case (cmd_reg)
                      8'h01:   scan_next = 1'b1;
                      8'h02:   scan_next = 1'b0;
                      8'h03:   rate_next = (arg_reg == 8'h00) ? 8'h01 : arg_reg;
                      default: ping_next = 1'b1;
                    endcase
                  end
                  default: err_inc = 1'b1;
                endcase
              end else begin
                err_inc = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (tmo == TIMEOUT_CYCLES - 16'd1) begin
          state_next = HUNT;
          tmo_next   = 16'd0;
          err_inc    = 1'b1;
        end else begin
          tmo_next = tmo + 16'd1;
        end
      end
    endcase

    if (err_inc && err_count != 8'hFF) err_next = err_count + 8'd1;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: fixed frame table, timeout,
// saturation and reset corner cases, then random frames against a frame-level model.
module tb_uart_cmd_decoder;

  localparam logic [15:0] TMO = 16'd64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       uld_rx_data, rx_enable, scan_enable, ping_pulse, cmd_valid;
  logic [7:0] rate_div, cmd_code, err_count;

  int tests = 0;
  int failed = 0;

  int valid_seen = 0;
  int ping_seen = 0;
  int ping_wide = 0;
  int uld_double = 0;
  logic ping_prev = 1'b0;
  logic uld_prev = 1'b0;

  logic       m_scan;
  logic [7:0] m_rate, m_err, m_code;

  typedef struct {
    int         n_garb;
    logic [7:0] g0, g1, cmd, arg, chk;
    logic       exp_scan;
    logic [7:0] exp_rate, exp_err, exp_code;
    int         exp_valid, exp_ping;
  } vec_t;

  vec_t vecs[7];

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .RATE_DEFAULT(8'd10)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .uld_rx_data(uld_rx_data), .rx_enable(rx_enable), .scan_enable(scan_enable),
    .rate_div(rate_div), .ping_pulse(ping_pulse), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .err_count(err_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cmd_valid) valid_seen <= valid_seen + 1;
    if (ping_pulse) ping_seen <= ping_seen + 1;
    if (ping_pulse && ping_prev) ping_wide <= ping_wide + 1;
    if (uld_rx_data && uld_prev) uld_double <= uld_double + 1;
    ping_prev <= ping_pulse;
    uld_prev  <= uld_rx_data;
  end

  task automatic check_output(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mimics the receiver: byte presented until unloaded, then empty for a few cycles
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clock);
    rx_data  = b;
    rx_empty = 1'b0;
    k = 0;
    @(negedge clock);
    while (!uld_rx_data && k < 20) begin
      @(negedge clock);
      k++;
    end
    check_output("uld_handshake", uld_rx_data, 1);
    rx_empty = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(arg);
    send_byte(chk);
    repeat (3) @(negedge clock);
  endtask

  task automatic model_reset();
    m_scan = 1'b0;
    m_rate = 8'd10;
    m_err  = 8'd0;
    m_code = 8'd0;
  endtask

  task automatic model_err();
    if (m_err < 8'd255) m_err = m_err + 8'd1;
  endtask

  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                             output int ev, output int ep);
    ev = 0;
    ep = 0;
    if (chk != (8'hA5 ^ cmd ^ arg) || cmd < 8'd1 || cmd > 8'd4) begin
      model_err();
    end else begin
      ev = 1;
      m_code = cmd;
      if (cmd == 8'd1) m_scan = 1'b1;
      if (cmd == 8'd2) m_scan = 1'b0;
      if (cmd == 8'd3) m_rate = (arg == 8'd0) ? 8'd1 : arg;
      if (cmd == 8'd4) ep = 1;
    end
  endtask

  task automatic check_model(input string tag, input int ev, input int ep, input int dv, input int dp);
    check_output({tag, "_scan"}, scan_enable, m_scan);
    check_output({tag, "_rate"}, rate_div, m_rate);
    check_output({tag, "_err"}, err_count, m_err);
    check_output({tag, "_code"}, cmd_code, m_code);
    check_output({tag, "_valid"}, dv, ev);
    check_output({tag, "_ping"}, dp, ep);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_uld"}, uld_rx_data, 0);
    check_output({tag, "_rxen"}, rx_enable, 0);
    check_output({tag, "_scan"}, scan_enable, 0);
    check_output({tag, "_rate"}, rate_div, 8'd10);
    check_output({tag, "_ping"}, ping_pulse, 0);
    check_output({tag, "_valid"}, cmd_valid, 0);
    check_output({tag, "_code"}, cmd_code, 0);
    check_output({tag, "_err"}, err_count, 0);
  endtask

  task automatic apply_stimulus();
    int v0, p0, ev, ep;
    for (int i = 0; i < 7; i++) begin
      v0 = valid_seen;
      p0 = ping_seen;
      if (vecs[i].n_garb > 0) send_byte(vecs[i].g0);
      if (vecs[i].n_garb > 1) send_byte(vecs[i].g1);
      send_frame(vecs[i].cmd, vecs[i].arg, vecs[i].chk);
      model_frame(vecs[i].cmd, vecs[i].arg, vecs[i].chk, ev, ep);
      check_output($sformatf("vec%0d_scan", i), scan_enable, vecs[i].exp_scan);
      check_output($sformatf("vec%0d_rate", i), rate_div, vecs[i].exp_rate);
      check_output($sformatf("vec%0d_err", i), err_count, vecs[i].exp_err);
      check_output($sformatf("vec%0d_code", i), cmd_code, vecs[i].exp_code);
      check_output($sformatf("vec%0d_valid", i), valid_seen - v0, vecs[i].exp_valid);
      check_output($sformatf("vec%0d_ping", i), ping_seen - p0, vecs[i].exp_ping);
    end
  endtask

  initial begin
    int v0, p0, ev, ep;
    logic [7:0] c, a, k, g;

    vecs[0] = '{0, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA4, 1'b1, 8'h0A, 8'h00, 8'h01, 1, 0};
    vecs[1] = '{0, 8'h00, 8'h00, 8'h03, 8'h20, 8'h86, 1'b1, 8'h20, 8'h00, 8'h03, 1, 0};
    vecs[2] = '{0, 8'h00, 8'h00, 8'h03, 8'h00, 8'hA6, 1'b1, 8'h01, 8'h00, 8'h03, 1, 0};
    vecs[3] = '{0, 8'h00, 8'h00, 8'h04, 8'h00, 8'hA1, 1'b1, 8'h01, 8'h00, 8'h04, 1, 1};
    vecs[4] = '{0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 8'h04, 0, 0};
    vecs[5] = '{2, 8'h11, 8'h22, 8'h02, 8'h00, 8'hA7, 1'b0, 8'h01, 8'h01, 8'h02, 1, 0};
    vecs[6] = '{0, 8'h00, 8'h00, 8'h07, 8'h00, 8'hA2, 1'b0, 8'h01, 8'h02, 8'h02, 0, 0};

    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clock);
    check_output("rxen_after_reset", rx_enable, 1);

    apply_stimulus();

    // Timeout: partial frame, then idle past the limit
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 10) @(negedge clock);
    check_output("tmo_before_expiry_err", err_count, m_err);
    repeat (20) @(negedge clock);
    model_err();
    check_output("tmo_expired_err", err_count, m_err);
    v0 = valid_seen; p0 = ping_seen;
    send_frame(8'h01, 8'h00, 8'hA4);
    model_frame(8'h01, 8'h00, 8'hA4, ev, ep);
    check_model("tmo_restart", ev, ep, valid_seen - v0, ping_seen - p0);

    // Error counter saturation
    v0 = valid_seen;
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h01, 8'h00, 8'h00);
      model_err();
    end
    check_output("sat_err", err_count, 8'd255);
    check_output("sat_err_model", err_count, m_err);
    check_output("sat_no_valid", valid_seen - v0, 0);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h01);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("midreset");
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_output("midreset_rxen", rx_enable, 1);
    v0 = valid_seen; p0 = ping_seen;
    send_frame(8'h01, 8'h00, 8'hA4);
    model_frame(8'h01, 8'h00, 8'hA4, ev, ep);
    check_model("post_reset", ev, ep, valid_seen - v0, ping_seen - p0);

    // Random frames with interleaved garbage
    for (int i = 0; i < 40; i++) begin
      v0 = valid_seen; p0 = ping_seen;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      c = 8'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      if (($urandom_range(0, 3)) != 0) k = 8'hA5 ^ c ^ a;
      else k = 8'($urandom_range(0, 255));
      send_frame(c, a, k);
      model_frame(c, a, k, ev, ep);
      check_model($sformatf("rnd%0d", i), ev, ep, valid_seen - v0, ping_seen - p0);
    end

    check_output("ping_width", ping_wide, 0);
    check_output("uld_spacing", uld_double, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Receive-side command decoder for the portable board's UART link. It drains bytes from the UART receiver through its `uld_rx_data`/`rx_data`/`rx_empty` handshake and parses 4-byte host command frames of the form 0xA5, CMD, ARG, CHK. From valid frames it drives the scan-control registers that gate the ADC/UART streaming path. It runs in the `pll_uart` clock domain alongside the UART transmit controller.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16'd50000: maximum idle cycles between bytes inside a frame.
- `RATE_DEFAULT`, default 8'd10: reset value of `rate_div`.

Ports:
- `clock` in 1: the `pll_uart` clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: byte from the UART receiver.
- `rx_empty` in 1: receiver holds no unread byte when 1.
- `uld_rx_data` out 1: one-cycle unload strobe to the receiver.
- `rx_enable` out 1: receiver enable.
- `scan_enable` out 1: level; 1 enables streaming.
- `rate_div` out 8: frame-rate divider for the scan controller.
- `ping_pulse` out 1: one-cycle pulse on a PING command.
- `cmd_valid` out 1: one-cycle pulse per accepted command.
- `cmd_code` out 8: CMD byte of the last accepted command.
- `err_count` out 8: saturating count of frame errors.

## Operation
- Reset values: `uld_rx_data`=0, `rx_enable`=0, `scan_enable`=0, `rate_div`=RATE_DEFAULT, `ping_pulse`=0, `cmd_valid`=0, `cmd_code`=0, `err_count`=0. Internal state: FSM=HUNT, pending=0, timeout counter=0.
- `rx_enable` is a register: 0 during reset, 1 from the first clock edge after reset deasserts.
- Byte fetch, independent of FSM state:
  - When `rx_empty`=0 and pending=0, register `uld_rx_data`<=1, byte_reg<=`rx_data`, pending<=1, byte_valid<=1.
  - pending clears on any edge where `rx_empty`=1.
  - `uld_rx_data` and byte_valid are never high for 2 consecutive cycles.
- FSM acts only in cycles where byte_valid=1:
  - HUNT: byte 0xA5 -> CMD. Any other byte is discarded, with no error.
  - CMD: store the byte as cmd -> ARG. 0xA5 here is treated as data; it does not resync the parser.
  - ARG: store the byte as arg -> CHK.
  - CHK: if byte == 0xA5 ^ cmd ^ arg, execute the command; otherwise increment `err_count`. Both cases -> HUNT.
- Commands, executed only with a good checksum:
  - 0x01 START: `scan_enable`<=1.
  - 0x02 STOP: `scan_enable`<=0.
  - 0x03 SET_RATE: `rate_div`<=arg. arg=0 is stored as 1.
  - 0x04 PING: `ping_pulse`<=1 for one cycle.
  - Any other code: no effect, `err_count`++, no `cmd_valid`.
- Each accepted command (0x01–0x04) sets `cmd_valid`<=1 for one cycle and `cmd_code`<=cmd.
- Timeout:
  - The counter clears in HUNT and on every byte_valid. It increments each cycle in CMD, ARG and CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_valid, FSM -> HUNT and `err_count`++.
  - If a byte and timeout expiry coincide, the byte wins and no error is counted.
- `err_count` saturates at 255 and never wraps.
- Reset mid-frame: FSM returns to HUNT and all outputs take their reset values, including `scan_enable`. A partial frame is discarded.

## Timing
- Edge n samples `rx_empty`=0. `uld_rx_data` and byte_valid are high during cycle n+1, and the FSM consumes the byte at edge n+1.
- Command effects (`scan_enable`, `rate_div`, `cmd_code`, `cmd_valid`, `ping_pulse`) are visible in cycle n+2, where n is the sampling edge of the CHK byte.
- A byte arriving immediately after an unload is fetched no earlier than the edge after `rx_empty` is seen as 1, then as 0 again.
- Throughput: the decoder keeps up with back-to-back UART bytes at any baud rate ≤ clock/4.

## Test plan
- Reset, then frame A5 01 00 A4 -> `cmd_valid` pulses once, `cmd_code`=0x01, `scan_enable`=1, `err_count`=0.
- Frame A5 03 20 86 -> `rate_div`=0x20. Then A5 03 00 A6 -> `rate_div`=0x01.
- Frame A5 04 00 A1 -> `ping_pulse` high exactly 1 cycle. Bad checksum A5 02 00 00 -> `scan_enable` unchanged, `err_count`=1, no `cmd_valid`.
- Garbage 11 22 then A5 02 00 A7 -> garbage ignored, `scan_enable`=0, `err_count` unchanged. A5 07 00 A2 (unknown code) -> `err_count`+1.
- A5 01 then TIMEOUT_CYCLES idle cycles -> FSM in HUNT, `err_count`+1. A following full START frame is accepted.
- 300 bad-checksum frames -> `err_count`=255. Assert `reset` mid-frame after A5 01 -> all outputs at reset values, and the next valid frame decodes correctly.
